// File: rtl/capture_framer.sv
// capture_framer: buffers 16-bit capture samples in a FIFO and frames them
// into byte packets (A5, seq, {drop_flag,len}, payload hi/lo...) for a USB
// streamer. Define CAPTURE_FRAMER_CSUM_EN to append an XOR checksum byte.
module capture_framer #(
    parameter int PKT_WORDS     = 8,
    parameter int FIFO_LOG_SIZE = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        have_space,
    output logic [7:0]  out_data,
    output logic        out_wr,
    output logic        busy,
    output logic [7:0]  drop_count
);
    localparam int DEPTH = 1 << FIFO_LOG_SIZE;
    localparam int CW    = FIFO_LOG_SIZE + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);
    localparam logic [31:0]   PKT_MAX     = 32'(PKT_WORDS);

    typedef enum logic [2:0] {
        IDLE, SYNC, SEQ, LEN, HI, LO
`ifdef CAPTURE_FRAMER_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t state, next_state;

    logic [FIFO_LOG_SIZE-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]            fifo_count;
    logic [15:0]              mem [DEPTH];
    logic [15:0]              head;
    logic                     full, push, pop, drop;
    logic [31:0]              count_ext;

    logic [7:0]    seq;
    logic          drop_flag;
    logic [TW-1:0] idle_timer;
    logic [6:0]    len, words_left, len_next;
    logic          start, emit, pkt_done;
    logic [7:0]    emit_byte;
`ifdef CAPTURE_FRAMER_CSUM_EN
    logic [7:0]    csum;
`endif

    assign full      = (fifo_count == FULL_CNT);
    assign push      = in_valid && !full;
    assign drop      = in_valid && full;
    assign head      = mem[rd_ptr];
    assign count_ext = 32'(fifo_count);
    // A packet never asks for more words than the FIFO holds at start, and
    // nothing else pops, so the FIFO cannot underflow mid-packet.
    assign len_next  = (count_ext >= PKT_MAX) ? 7'(PKT_WORDS) : 7'(count_ext);
    assign busy      = (state != IDLE);

    // FIFO pointers and occupancy; contents are discarded by reset
    always_ff @(posedge mclk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage (no reset needed, validity tracked by pointers)
    always_ff @(posedge mclk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // State register
    always_ff @(posedge mclk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and byte selection; every byte state stalls on !have_space
    always_comb begin
        next_state = state;
        start      = 1'b0;
        emit       = 1'b0;
        emit_byte  = 8'h00;
        pop        = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            IDLE: begin
                if (have_space && (count_ext >= PKT_MAX ||
                    (fifo_count != '0 && idle_timer == TIMEOUT_CNT))) begin
                    start      = 1'b1;
                    next_state = SYNC;
                end
            end
            SYNC: if (have_space) begin
                emit = 1'b1; emit_byte = 8'hA5; next_state = SEQ;
            end
            SEQ: if (have_space) begin
                emit = 1'b1; emit_byte = seq; next_state = LEN;
            end
            LEN: if (have_space) begin
                emit = 1'b1; emit_byte = {drop_flag, len}; next_state = HI;
            end
            HI: if (have_space) begin
                emit = 1'b1; emit_byte = head[15:8]; next_state = LO;
            end
            LO: if (have_space) begin
                emit      = 1'b1;
                emit_byte = head[7:0];
                pop       = 1'b1;
                if (words_left == 7'd1) begin
`ifdef CAPTURE_FRAMER_CSUM_EN
                    next_state = CSUM;
`else
                    next_state = IDLE;
                    pkt_done   = 1'b1;
`endif
                end else begin
                    next_state = HI;
                end
            end
`ifdef CAPTURE_FRAMER_CSUM_EN
            CSUM: if (have_space) begin
                emit = 1'b1; emit_byte = csum; next_state = IDLE; pkt_done = 1'b1;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Packet length, remaining-word count and sequence number
    always_ff @(posedge mclk) begin
        if (!reset) begin
            len        <= '0;
            words_left <= '0;
            seq        <= '0;
        end else begin
            if (start) begin
                len        <= len_next;
                words_left <= len_next;
            end else if (pop) begin
                words_left <= words_left - 1'b1;
            end
            if (pkt_done) seq <= seq + 1'b1;
        end
    end

    // Drop accounting; a drop in the LEN cycle keeps the flag for next packet
    always_ff @(posedge mclk) begin
        if (!reset) begin
            drop_flag  <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            drop_flag <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end else if (state == LEN && emit) begin
            drop_flag <= 1'b0;
        end
    end

    // Idle timer: flushes a short packet once data has waited TIMEOUT cycles
    always_ff @(posedge mclk) begin
        if (!reset || state != IDLE || fifo_count == '0 || start)
            idle_timer <= '0;
        else if (idle_timer != TIMEOUT_CNT)
            idle_timer <= idle_timer + 1'b1;
    end

    // Registered byte output; out_data holds the last byte between writes
    always_ff @(posedge mclk) begin
        if (!reset) begin
            out_wr   <= 1'b0;
            out_data <= 8'h00;
        end else begin
            out_wr <= emit;
            if (emit) out_data <= emit_byte;
        end
    end

`ifdef CAPTURE_FRAMER_CSUM_EN
    // Running XOR over every byte emitted in the current packet
    always_ff @(posedge mclk) begin
        if (!reset || start) csum <= 8'h00;
        else if (emit)       csum <= csum ^ emit_byte;
    end
`endif

endmodule

// File: tb/tb_capture_framer.sv
// Self-checking bench for capture_framer: randomized words, packet-level
// reference model built from queues.
module tb_capture_framer;
    localparam int PKT   = 8;
    localparam int DEPTH = 16;
`ifdef CAPTURE_FRAMER_CSUM_EN
    localparam int CSUM_B = 1;
`else
    localparam int CSUM_B = 0;
`endif
    localparam int PLEN8 = 3 + 2 * PKT + CSUM_B;

    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        have_space = 1'b1;
    logic [7:0]  out_data;
    logic        out_wr;
    logic        busy;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] stim[$];
    logic [15:0] m_fifo[$];
    logic [7:0]  m_seq = 8'h00;
    logic        m_flag = 1'b0;
    int          m_drops = 0;

    capture_framer #(.PKT_WORDS(PKT), .FIFO_LOG_SIZE(4), .TIMEOUT(1024)) dut (
        .mclk(mclk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .have_space(have_space), .out_data(out_data), .out_wr(out_wr),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 mclk = ~mclk;

    // Byte monitor, sampled just after the active edge
    always @(posedge mclk) begin
        #1;
        if (out_wr === 1'b1) got_q.push_back(out_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_push(input logic [15:0] w);
        if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
        else begin
            m_flag = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic model_packet();
        int n;
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [15:0] w;
        n = (m_fifo.size() < PKT) ? m_fifo.size() : PKT;
        b.push_back(8'hA5);
        b.push_back(m_seq);
        b.push_back({m_flag, 7'(n)});
        for (int i = 0; i < n; i++) begin
            w = m_fifo.pop_front();
            b.push_back(w[15:8]);
            b.push_back(w[7:0]);
        end
        if (CSUM_B == 1) begin
            x = 8'h00;
            foreach (b[i]) x = x ^ b[i];
            b.push_back(x);
        end
        foreach (b[i]) exp_q.push_back(b[i]);
        m_seq  = m_seq + 8'd1;
        m_flag = 1'b0;
    endtask

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic push_stim();
        foreach (stim[i]) begin
            in_data  = stim[i];
            in_valid = 1'b1;
            model_push(stim[i]);
            @(negedge mclk);
        end
        in_valid = 1'b0;
        stim.delete();
    endtask

    task automatic rand_stim(input int n);
        for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
    endtask

    task automatic wait_bytes(input int bound);
        int cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < bound) begin
            @(negedge mclk);
            cyc++;
        end
        repeat (20) @(negedge mclk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; have_space = 1'b1;
        repeat (3) @(negedge mclk);
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count: got %h want 00", drop_count); end
        reset = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_full_packet();
        for (int i = 0; i < 8; i++) stim.push_back({8'(i + 1), 8'(i + 2)});
        push_stim();
        model_packet();
        wait_bytes(200);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_pkt_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_pkt_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 2) begin
            checks++; if (got_q[1] !== 8'h00 || got_q[2] !== 8'h08) begin errors++; $display("FAIL full_pkt_hdr: got %h %h want 00 08", got_q[1], got_q[2]); end
        end
        got_q.delete(); exp_q.delete();
        rand_stim(8);
        push_stim();
        model_packet();
        wait_bytes(200);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL pkt2_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pkt2_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 1) begin
            checks++; if (got_q[1] !== 8'h01) begin errors++; $display("FAIL pkt2_seq: got %h want 01", got_q[1]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        logic quiet = 1'b1;
        rand_stim(3);
        push_stim();
        repeat (1021) begin
            @(negedge mclk);
            if (out_wr !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || got_q.size() != 0) begin errors++; $display("FAIL timeout_quiet: got %0d early bytes want 0", got_q.size()); end
        model_packet();
        wait_bytes(200);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 2) begin
            checks++; if (got_q[2] !== 8'h03) begin errors++; $display("FAIL timeout_lenbyte: got %h want 03", got_q[2]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        rand_stim(8);
        push_stim();
        model_packet();
        while (got_q.size() < 7 && cyc < 100) begin @(negedge mclk); cyc++; end
        have_space = 1'b0;
        repeat (5) begin
            @(posedge mclk); #1;
            checks++; if (out_wr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall: got out_wr=%b busy=%b want 0 1", out_wr, busy); end
        end
        @(negedge mclk);
        have_space = 1'b1;
        wait_bytes(200);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_drop(input int n_words, input string tag);
        have_space = 1'b0;
        rand_stim(n_words);
        push_stim();
        checks++; if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL %s_count: got %0d want %0d", tag, drop_count, m_drops); end
        have_space = 1'b1;
        model_packet();
        model_packet();
        wait_bytes(300);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_len: got %0d want %0d", tag, got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > PLEN8 + 2) begin
            checks++; if (got_q[2] !== 8'h88 || got_q[PLEN8 + 2] !== 8'h08) begin errors++; $display("FAIL %s_lenbytes: got %h %h want 88 08", tag, got_q[2], got_q[PLEN8 + 2]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int idx = 0;
            rand_stim(16);
            while (idx < 16) begin
                have_space = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    in_data = stim[idx]; in_valid = 1'b1;
                    model_push(stim[idx]);
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge mclk);
            end
            in_valid = 1'b0; have_space = 1'b1;
            stim.delete();
            model_packet();
            model_packet();
            wait_bytes(400);
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", it, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        rand_stim(8);
        push_stim();
        while (got_q.size() < 3 && cyc < 100) begin @(negedge mclk); cyc++; end
        reset = 1'b0;
        @(posedge mclk); #1;
        checks++; if (out_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset: got out_wr=%b busy=%b want 0 0", out_wr, busy); end
        @(negedge mclk);
        reset = 1'b1;
        m_fifo.delete(); m_seq = 8'h00; m_flag = 1'b0; m_drops = 0;
        repeat (10) @(negedge mclk);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL midreset_abort: got %0d bytes want 3", got_q.size()); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL midreset_drops: got %h want 00", drop_count); end
        got_q.delete();
        // Single word after reset: stale FIFO data would make this a full packet
        stim.push_back(16'h1234);
        push_stim();
        m_fifo.delete();
        exp_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        if (CSUM_B == 1) exp_q.push_back(8'h82);
        wait_bytes(1200);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL csum_pkt_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL csum_pkt_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        @(negedge mclk);
        test_reset();
        test_full_packet();
        test_timeout();
        test_backpressure();
        test_drop(20, "drop");
        test_drop(DEPTH + 260, "dropsat");
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
